// File: rtl/lsu_byte_sequencer_if.sv
// Request/response handshake and byte-wide memory bus for the load/store sequencer.
// The sequencer connects through the slave modport; execute, writeback and memory sit on master.
interface lsu_byte_sequencer_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_misaligned;
    logic                  resp_fault;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [7:0]            mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// RV32I load/store sequencer: validates a request, then performs 1/2/4 little-endian byte
// accesses on a byte-wide memory and returns the extended load data on a response handshake.
module lsu_byte_sequencer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_BYTES    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    lsu_byte_sequencer_if.slave bus
);
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t                state;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata;
    logic [31:0]           acc;
    logic [1:0]            idx;
    logic [LAT_W-1:0]      lat_cnt;

    logic [1:0]            req_size;
    logic [1:0]            req_last;
    logic                  req_misaligned;
    logic                  req_legal;
    logic [AW1-1:0]        req_end;
    logic                  req_out_of_range;
    logic [1:0]            last_idx;
    logic [1:0]            idx_inc;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [31:0]           acc_next;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   return f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    always_comb begin
        req_size = bus.req_funct3[1:0];
        case (req_size)
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
        req_misaligned = ((req_size == 2'b01) && bus.req_addr[0]) ||
                         ((req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        if (bus.req_is_store)
            req_legal = !bus.req_funct3[2] && (req_size != 2'b11);
        else
            req_legal = (req_size != 2'b11) && !(bus.req_funct3[2] && (req_size == 2'b10));
        // One extra bit so an address near the top of the space cannot wrap past the check.
        req_end          = {1'b0, bus.req_addr} + AW1'(req_last);
        req_out_of_range = req_end >= AW1'(MEM_BYTES);

        case (funct3[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
        idx_inc   = idx + 2'd1;
        next_addr = base + ADDR_WIDTH'(idx_inc);
        acc_next  = acc;
        acc_next[{idx, 3'b000} +: 8] = bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            is_store            <= 1'b0;
            funct3              <= '0;
            base                <= '0;
            wdata               <= '0;
            acc                 <= '0;
            idx                 <= '0;
            lat_cnt             <= '0;
            bus.req_ready       <= 1'b1;
            bus.resp_valid      <= 1'b0;
            bus.resp_rdata      <= '0;
            bus.resp_misaligned <= 1'b0;
            bus.resp_fault      <= 1'b0;
            bus.mem_addr        <= '0;
            bus.mem_wdata       <= '0;
            bus.mem_we          <= 1'b0;
            bus.mem_re          <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            bus.mem_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_store      <= bus.req_is_store;
                        funct3        <= bus.req_funct3;
                        base          <= bus.req_addr;
                        wdata         <= bus.req_wdata;
                        idx           <= '0;
                        acc           <= '0;
                        bus.req_ready <= 1'b0;
                        if (req_misaligned) begin
                            state               <= DONE;
                            bus.resp_valid      <= 1'b1;
                            bus.resp_misaligned <= 1'b1;
                        end else if (!req_legal || req_out_of_range) begin
                            state          <= DONE;
                            bus.resp_valid <= 1'b1;
                            bus.resp_fault <= 1'b1;
                        end else begin
                            // Byte 0 strobe is registered here so it appears during the first ACCESS cycle.
                            state        <= ACCESS;
                            bus.mem_addr <= bus.req_addr;
                            if (bus.req_is_store) begin
                                bus.mem_we    <= 1'b1;
                                bus.mem_wdata <= bus.req_wdata[7:0];
                            end else begin
                                bus.mem_re    <= 1'b1;
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (is_store) begin
                        if (idx == last_idx) begin
                            state          <= DONE;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            idx           <= idx_inc;
                            bus.mem_addr  <= next_addr;
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= wdata[{idx_inc, 3'b000} +: 8];
                        end
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_W'(READ_LATENCY - 1);
                    end
                end

                WAIT: begin
                    if (lat_cnt == '0) begin
                        acc <= acc_next;
                        if (idx == last_idx) begin
                            state          <= DONE;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= extend(acc_next, funct3);
                        end else begin
                            idx          <= idx_inc;
                            state        <= ACCESS;
                            bus.mem_addr <= next_addr;
                            bus.mem_re   <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                DONE: begin
                    if (bus.resp_ready) begin
                        state               <= IDLE;
                        bus.req_ready       <= 1'b1;
                        bus.resp_valid      <= 1'b0;
                        bus.resp_rdata      <= '0;
                        bus.resp_misaligned <= 1'b0;
                        bus.resp_fault      <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
